regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single 64-bit register-file write port between two requesters, e.g. ALU writeback (port 0) and load-data return (port 1).
- Arbitrates round-robin, registers the winner, and drives the write-port controls: RegWrite, WriteRegister, WriteData.
- Also drives the select for the 64-bit 2:1 data mux in front of the register file.
- Sits between the execute/memory stages and the 32x64 register file.

Parameters:
- DATA_W, 64, write data width.
- ADDR_W, 5, register address width (32 registers).
- ZERO_REG, 31, hardwired-zero register index; writes to it are accepted but discarded.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 transfer accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 destination register.
- req1_data  in  DATA_W  requester 1 write data.
- req1_ready  out  1  requester 1 transfer accepted this cycle (combinational).
- wr_stall  in  1  register-file port unavailable; hold the current output.
- RegWrite  out  1  write enable to the register file.
- WriteRegister  out  ADDR_W  write address.
- WriteData  out  DATA_W  write data.
- mux_sel  out  1  source of the registered write: 0 = req0, 1 = req1.

Behaviour:
- Synchronous, active-low reset. Reset is sampled only on a rising clk edge with reset_n=0.
  - Reset values: RegWrite=0, WriteRegister=0, WriteData=0, mux_sel=0, last_grant=1.
  - last_grant=1 means req0 has priority first.
- Handshake: a transfer occurs on reqN when reqN_valid=1 and reqN_ready=1 in the same cycle.
  - reqN_ready never depends on reqN_data or reqN_addr.
  - reqN_ready is 0 whenever reqN_valid=0.
- Grant rules, evaluated each cycle with wr_stall=0 and reset_n=1:
  - Only req0 valid: grant req0.
  - Only req1 valid: grant req1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant; last_grant unchanged.
  - At most one ready is high per cycle.
- On a grant, at the next edge:
  - last_grant <= winner; mux_sel <= winner.
  - WriteRegister <= winner addr; WriteData <= winner data.
  - RegWrite <= 1, except RegWrite <= 0 if winner addr == ZERO_REG (the transfer is still accepted and consumed).
- No grant with wr_stall=0: RegWrite <= 0 at the next edge. WriteRegister, WriteData and mux_sel hold.
- Latency: exactly 1 cycle from accepting handshake to RegWrite/WriteData valid at the register file.
- Throughput: one write per cycle when unstalled.
- wr_stall=1:
  - Both readys are 0.
  - All outputs, including RegWrite, hold their values.
  - last_grant holds.
  - The held write is committed in the first cycle wr_stall returns to 0.
  - A new grant is allowed in that same cycle; its result appears at the following edge.
- Fairness: with both requesters continuously valid, grants strictly alternate. Neither requester waits more than 1 cycle of unstalled time.
- Same-address conflict: both requesters targeting the same register are serialized in grant order. The later grant wins in the register file. No merging.
- Reset mid-stall or mid-stream discards any held write. No pending state survives reset.
- Inputs may change freely while a requester is not granted. A requester must hold valid/addr/data stable until ready.

Test Plan:
- Reset: reset_n=0 for 2 cycles with both requesters valid -> both readys 0, RegWrite=0, WriteData=0, mux_sel=0. First cycle after release grants req0.
- Single requester: req0 writes addr 3, data 64'd64357 -> req0_ready=1 that cycle. Next cycle RegWrite=1, WriteRegister=3, WriteData=64357, mux_sel=0. The cycle after, RegWrite=0.
- Contention: both valid continuously for 4 cycles (req0 addr 1 data 26000, req1 addr 2 data 7) -> grants go req0, req1, req0, req1. mux_sel follows 0,1,0,1 one cycle later.
- Zero register: req1 writes addr 31, data 64'hFFFF -> req1_ready=1. Next cycle RegWrite=0 and mux_sel=1.
- Stall: grant req0 (addr 5) then hold wr_stall=1 for 3 cycles with req1 valid -> readys 0 and RegWrite=1 / WriteRegister=5 held for 3 cycles. On release req1 is granted, with outputs updating one cycle later.
- Reset mid-stall: during the stall case, assert reset_n=0 for 1 cycle -> RegWrite=0 and the held write is gone. After release req0 has priority.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Bundles the two requester channels and the register-file write port
// that the write-port arbiter sits between.
interface regfile_wr_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              wr_stall;
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [DATA_W-1:0] WriteData;
   logic              mux_sel;

   // Requesters and the register file together form the master side.
   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      output wr_stall,
      input  req0_ready, req1_ready,
      input  RegWrite, WriteRegister, WriteData, mux_sel
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      input  wr_stall,
      output req0_ready, req1_ready,
      output RegWrite, WriteRegister, WriteData, mux_sel
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between
// ALU writeback (req0) and load-data return (req1); the winner is registered.
module regfile_wr_arbiter #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
) (
   input logic                 clk,
   input logic                 reset_n,
   regfile_wr_arbiter_if.slave bus
);

   logic              lastGrant_q,     lastGrant_d;
   logic              regWrite_q,      regWrite_d;
   logic [ADDR_W-1:0] writeRegister_q, writeRegister_d;
   logic [DATA_W-1:0] writeData_q,     writeData_d;
   logic              muxSel_q,        muxSel_d;

   logic              grant0;
   logic              grant1;
   logic              winnerSel;
   logic [ADDR_W-1:0] winnerAddr;
   logic [DATA_W-1:0] winnerData;

   // Grants are suppressed in reset so no transfer is consumed and then lost.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (reset_n && !bus.wr_stall) begin
         if (bus.req0_valid && (!bus.req1_valid || lastGrant_q)) begin
            grant0 = 1'b1;
         end else if (bus.req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   always_comb begin
      winnerSel  = grant1;
      winnerAddr = grant1 ? bus.req1_addr : bus.req0_addr;
      winnerData = grant1 ? bus.req1_data : bus.req0_data;
   end

   // Writes to the hardwired-zero register are consumed but never enabled.
   always_comb begin
      lastGrant_d     = lastGrant_q;
      regWrite_d      = regWrite_q;
      writeRegister_d = writeRegister_q;
      writeData_d     = writeData_q;
      muxSel_d        = muxSel_q;
      if (!bus.wr_stall) begin
         if (grant0 || grant1) begin
            lastGrant_d     = winnerSel;
            muxSel_d        = winnerSel;
            writeRegister_d = winnerAddr;
            writeData_d     = winnerData;
            regWrite_d      = (winnerAddr != ADDR_W'(ZERO_REG));
         end else begin
            regWrite_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lastGrant_q     <= 1'b1;
         regWrite_q      <= 1'b0;
         writeRegister_q <= '0;
         writeData_q     <= '0;
         muxSel_q        <= 1'b0;
      end else begin
         lastGrant_q     <= lastGrant_d;
         regWrite_q      <= regWrite_d;
         writeRegister_q <= writeRegister_d;
         writeData_q     <= writeData_d;
         muxSel_q        <= muxSel_d;
      end
   end

   assign bus.req0_ready    = grant0;
   assign bus.req1_ready    = grant1;
   assign bus.RegWrite      = regWrite_q;
   assign bus.WriteRegister = writeRegister_q;
   assign bus.WriteData     = writeData_q;
   assign bus.mux_sel       = muxSel_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, single writes, contention,
// zero-register discard, stall hold and reset during a stall.
module tb_regfile_wr_arbiter;

   logic clk = 1'b0;
   logic reset_n;
   int   checkCount = 0;
   int   failCount  = 0;

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                                input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                                input logic stall);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      bus.wr_stall   = stall;
      #1;
   endtask

   task automatic checkReady(input string tag, input logic r0, input logic r1);
      checkOutput({tag, ".ready0"}, 64'(bus.req0_ready), 64'(r0));
      checkOutput({tag, ".ready1"}, 64'(bus.req1_ready), 64'(r1));
   endtask

   task automatic checkWrite(input string tag, input logic rw, input logic [4:0] wr,
                             input logic [63:0] wd, input logic ms);
      checkOutput({tag, ".RegWrite"},      64'(bus.RegWrite),      64'(rw));
      checkOutput({tag, ".WriteRegister"}, 64'(bus.WriteRegister), 64'(wr));
      checkOutput({tag, ".WriteData"},     bus.WriteData,          wd);
      checkOutput({tag, ".mux_sel"},       64'(bus.mux_sel),       64'(ms));
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      applyStimulus(1'b1, 5'd1, 64'd10, 1'b1, 5'd2, 64'd20, 1'b0);

      // Reset held two edges with both requesters valid.
      nextEdge();
      nextEdge();
      checkReady("reset", 1'b0, 1'b0);
      checkWrite("reset", 1'b0, 5'd0, 64'd0, 1'b0);

      reset_n = 1'b1;
      #1;
      checkReady("firstAfterReset", 1'b1, 1'b0);
      nextEdge();
      checkWrite("firstAfterReset", 1'b1, 5'd1, 64'd10, 1'b0);

      // Single requester 0 write, then idle.
      applyStimulus(1'b1, 5'd3, 64'd64357, 1'b0, 5'd0, 64'd0, 1'b0);
      checkReady("single", 1'b1, 1'b0);
      nextEdge();
      checkWrite("single", 1'b1, 5'd3, 64'd64357, 1'b0);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      checkReady("idle", 1'b0, 1'b0);
      nextEdge();
      checkWrite("idle", 1'b0, 5'd3, 64'd64357, 1'b0);

      // Zero register: accepted, RegWrite stays low.
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFFFF, 1'b0);
      checkReady("zeroReg", 1'b0, 1'b1);
      nextEdge();
      checkWrite("zeroReg", 1'b0, 5'd31, 64'hFFFF, 1'b1);

      // Contention: last grant was req1, so req0 goes first and they alternate.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'd1, 64'd26000, 1'b1, 5'd2, 64'd7, 1'b0);
         checkReady($sformatf("contend%0d", i), (i % 2) == 0, (i % 2) == 1);
         nextEdge();
         if ((i % 2) == 0) checkWrite($sformatf("contend%0d", i), 1'b1, 5'd1, 64'd26000, 1'b0);
         else              checkWrite($sformatf("contend%0d", i), 1'b1, 5'd2, 64'd7, 1'b1);
      end

      // Stall: req0 write to r5 held for three cycles while req1 waits.
      applyStimulus(1'b1, 5'd5, 64'd55, 1'b0, 5'd0, 64'd0, 1'b0);
      checkReady("preStall", 1'b1, 1'b0);
      nextEdge();
      checkWrite("preStall", 1'b1, 5'd5, 64'd55, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'd66, 1'b1);
         checkReady($sformatf("stall%0d", i), 1'b0, 1'b0);
         nextEdge();
         checkWrite($sformatf("stall%0d", i), 1'b1, 5'd5, 64'd55, 1'b0);
      end
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'd66, 1'b0);
      checkReady("stallRelease", 1'b0, 1'b1);
      nextEdge();
      checkWrite("stallRelease", 1'b1, 5'd6, 64'd66, 1'b1);

      // Reset during a stall: held write dropped, req0 regains priority.
      applyStimulus(1'b1, 5'd8, 64'd88, 1'b0, 5'd0, 64'd0, 1'b0);
      checkReady("preMidReset", 1'b1, 1'b0);
      nextEdge();
      checkWrite("preMidReset", 1'b1, 5'd8, 64'd88, 1'b0);
      applyStimulus(1'b1, 5'd9, 64'd99, 1'b1, 5'd10, 64'd100, 1'b1);
      checkReady("midStall", 1'b0, 1'b0);
      nextEdge();
      checkWrite("midStall", 1'b1, 5'd8, 64'd88, 1'b0);
      reset_n = 1'b0;
      #1;
      checkReady("midReset", 1'b0, 1'b0);
      nextEdge();
      checkWrite("midReset", 1'b0, 5'd0, 64'd0, 1'b0);
      reset_n = 1'b1;
      applyStimulus(1'b1, 5'd9, 64'd99, 1'b1, 5'd10, 64'd100, 1'b0);
      checkReady("afterMidReset", 1'b1, 1'b0);
      nextEdge();
      checkWrite("afterMidReset", 1'b1, 5'd9, 64'd99, 1'b0);

      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      nextEdge();
      checkOutput("drain.RegWrite", 64'(bus.RegWrite), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
